tpm_ram_arbiter: RTL and testbench

TPM_RAM_ARBITER -- requirements
Module: tpm_ram_arbiter

---
 rtl/tpm_ram_arbiter_if.sv | 44 ++++
 rtl/tpm_ram_arbiter.sv | 106 ++++++++++
 tb/tb_tpm_ram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_ram_arbiter_if.sv
// Bus bundle between the TPM RAM arbiter, its Wishbone master, the data provider and the RAM.
// Signal directions (_i/_o) are named from the arbiter's point of view.
interface tpm_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [3:0]            wb_sel_i;
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [31:0]           wb_dat_i;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_o;

    logic                  dp_req_i;
    logic                  dp_we_i;
    logic [ADDR_WIDTH-1:0] dp_addr_i;
    logic [7:0]            dp_dat_i;
    logic [7:0]            dp_dat_o;
    logic                  dp_ack_o;

    logic [ADDR_WIDTH-3:0] ram_a_o;
    logic [31:0]           ram_wd_o;
    logic [3:0]            ram_wen_o;
    logic [31:0]           ram_rd_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o,
        input  dp_req_i, dp_we_i, dp_addr_i, dp_dat_i,
        output dp_dat_o, dp_ack_o,
        output ram_a_o, ram_wd_o, ram_wen_o,
        input  ram_rd_i
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o,
        output dp_req_i, dp_we_i, dp_addr_i, dp_dat_i,
        input  dp_dat_o, dp_ack_o,
        input  ram_a_o, ram_wd_o, ram_wen_o,
        output ram_rd_i
    );
endinterface

// File: rtl/tpm_ram_arbiter.sv
// Two-port arbiter sharing one 32-bit TPM command/response RAM between Wishbone and a byte-wide
// data provider; exec_i picks the priority side, a starvation counter guarantees the other side progress.
//   state   | meaning
//   IDLE    | arbitrate; the granted side drives the RAM this cycle
//   RESP_WB | Wishbone ack with RAM read word
//   RESP_DP | data-provider ack with selected RAM byte lane
module tpm_ram_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exec_i,
    tpm_ram_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RESP_WB, RESP_DP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [1:0]    dp_lane_q, dp_lane_d;
    logic          dp_we_q, dp_we_d;
    logic [7:0]    dp_dat_q, dp_dat_d;

    logic       wb_pend, dp_pend, contended, starved, arbitrate;
    logic       grant_wb, grant_dp;
    logic [7:0] rd_lane;
    logic       unused_wb_adr;

    assign unused_wb_adr = ^bus.wb_adr_i[1:0];

    // Grant is combinational so the RAM sees the winner's address in the arbitration cycle itself.
    assign wb_pend   = bus.wb_cyc_i & bus.wb_stb_i;
    assign dp_pend   = bus.dp_req_i;
    assign contended = wb_pend & dp_pend;
    assign starved   = (starve_cnt_q == CW'(STARVE_LIMIT));
    assign arbitrate = (state_q == IDLE) & ~rst_i;
    assign grant_wb  = arbitrate & wb_pend & (~dp_pend | (exec_i ^ starved));
    assign grant_dp  = arbitrate & dp_pend & ~grant_wb;
    assign rd_lane   = bus.ram_rd_i[{dp_lane_q, 3'b000} +: 8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            dp_lane_q    <= '0;
            dp_we_q      <= 1'b0;
            dp_dat_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dp_lane_q    <= dp_lane_d;
            dp_we_q      <= dp_we_d;
            dp_dat_q     <= dp_dat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dp_lane_d    = dp_lane_q;
        dp_we_d      = dp_we_q;
        dp_dat_d     = dp_dat_q;
        case (state_q)
            IDLE: begin
                if (grant_wb)      state_d = RESP_WB;
                else if (grant_dp) state_d = RESP_DP;
            end
            RESP_WB: state_d = IDLE;
            RESP_DP: begin
                state_d = IDLE;
                if (!dp_we_q) dp_dat_d = rd_lane;
            end
            default: state_d = IDLE;
        endcase
        if (grant_dp) begin
            dp_lane_d = bus.dp_addr_i[1:0];
            dp_we_d   = bus.dp_we_i;
        end
        // Under contention an unstarved grant always goes to the priority side.
        if (grant_wb | grant_dp) begin
            if (contended && !starved) starve_cnt_d = starve_cnt_q + 1'b1;
            else                       starve_cnt_d = '0;
        end
    end

    always_comb begin
        bus.ram_a_o   = '0;
        bus.ram_wd_o  = '0;
        bus.ram_wen_o = '0;
        if (grant_wb) begin
            bus.ram_a_o   = bus.wb_adr_i[ADDR_WIDTH-1:2];
            bus.ram_wd_o  = bus.wb_dat_i;
            bus.ram_wen_o = bus.wb_we_i ? bus.wb_sel_i : 4'b0000;
        end else if (grant_dp) begin
            bus.ram_a_o   = bus.dp_addr_i[ADDR_WIDTH-1:2];
            bus.ram_wd_o  = {4{bus.dp_dat_i}};
            bus.ram_wen_o = bus.dp_we_i ? (4'b0001 << bus.dp_addr_i[1:0]) : 4'b0000;
        end
        bus.wb_ack_o = (state_q == RESP_WB);
        bus.wb_dat_o = bus.wb_ack_o ? bus.ram_rd_i : 32'h0;
        bus.dp_ack_o = (state_q == RESP_DP);
        bus.dp_dat_o = (bus.dp_ack_o && !dp_we_q) ? rd_lane : dp_dat_q;
    end
endmodule

// File: tb/tb_tpm_ram_arbiter.sv
// Self-checking bench for tpm_ram_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model with a byte-array RAM image.
module tb_tpm_ram_arbiter;
    localparam int AW = 11;
    localparam int SL = 4;
    localparam int NV = 13;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic exec_i = 1'b0;

    tpm_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus();

    tpm_ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .exec_i (exec_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // RAM behaviour: synchronous byte-write, read data one cycle after address.
    logic [31:0] ram [0:(1<<(AW-2))-1];
    logic [31:0] ram_rd_q = 32'h0;
    logic        ram_init_done = 1'b0;
    assign bus.ram_rd_i = ram_rd_q;

    always @(posedge clk_i) begin
        if (!ram_init_done) begin
            for (int k = 0; k < (1<<(AW-2)); k++) ram[k] <= 32'h0;
            ram_init_done <= 1'b1;
        end else begin
            for (int n = 0; n < 4; n++)
                if (bus.ram_wen_o[n]) ram[bus.ram_a_o][8*n +: 8] <= bus.ram_wd_o[8*n +: 8];
            ram_rd_q <= ram[bus.ram_a_o];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference image of RAM contents, byte addressed.
    logic [7:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [31:0] ref_word(input logic [AW-1:0] adr);
        logic [AW-1:0] b;
        b = {adr[AW-1:2], 2'b00};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_wb_write(input logic [3:0] sel, input logic [AW-1:0] adr, input logic [31:0] dat);
        logic [AW-1:0] b;
        b = {adr[AW-1:2], 2'b00};
        for (int n = 0; n < 4; n++)
            if (sel[n]) ref_mem[b + AW'(n)] = dat[8*n +: 8];
    endtask

    task automatic drive_idle();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = 4'h0; bus.wb_adr_i = '0;   bus.wb_dat_i = 32'h0;
        bus.dp_req_i = 1'b0; bus.dp_we_i = 1'b0;  bus.dp_addr_i = '0; bus.dp_dat_i = 8'h0;
    endtask

    task automatic set_wb(input logic we, input logic [3:0] sel, input logic [AW-1:0] adr, input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_sel_i = sel;  bus.wb_adr_i = adr;  bus.wb_dat_i = dat;
    endtask

    task automatic set_dp(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat);
        bus.dp_req_i = 1'b1; bus.dp_we_i = we; bus.dp_addr_i = adr; bus.dp_dat_i = dat;
    endtask

    typedef struct {
        logic            exec;
        logic            wb_req;
        logic            wb_we;
        logic [3:0]      sel;
        logic [AW-1:0]   wb_adr;
        logic [31:0]     wb_dat;
        logic            dp_req;
        logic            dp_we;
        logic [AW-1:0]   dp_adr;
        logic [7:0]      dp_dat;
        logic [AW-3:0]   e_a;
        logic [31:0]     e_wd;
        logic [3:0]      e_wen;
        logic            e_wb;
        logic [31:0]     e_wbdat;
        logic [7:0]      e_dpdat;
    } vec_t;

    vec_t vt [NV];

    typedef struct {
        logic        is_wb;
        logic [31:0] wbdat;
        logic        dp_rd;
        logic [7:0]  dpdat;
    } exp_t;

    exp_t        exp_q [$];
    int          m_cnt;
    logic [7:0]  m_dpdat;

    initial begin
        logic [1:0]  acks [$];
        logic [1:0]  exp_order [10];
        int          nack;

        //          exec wb  we  sel    adr     dat            dp  we  adr     dat     e_a     e_wd           e_wen e_wb e_wbdat        e_dpdat
        vt[0]  = '{1'b0,1'b1,1'b1,4'hF,11'h010,32'hCAFEBABE,1'b0,1'b0,11'h000,8'h00, 9'h004,32'hCAFEBABE,4'hF,1'b1,32'h00000000,8'h00};
        vt[1]  = '{1'b0,1'b1,1'b0,4'hF,11'h010,32'h00000000,1'b0,1'b0,11'h000,8'h00, 9'h004,32'h00000000,4'h0,1'b1,32'hCAFEBABE,8'h00};
        vt[2]  = '{1'b0,1'b0,1'b0,4'h0,11'h000,32'h00000000,1'b1,1'b1,11'h013,8'h5A, 9'h004,32'h5A5A5A5A,4'h8,1'b0,32'h00000000,8'h00};
        vt[3]  = '{1'b0,1'b0,1'b0,4'h0,11'h000,32'h00000000,1'b1,1'b0,11'h013,8'h00, 9'h004,32'h00000000,4'h0,1'b0,32'h00000000,8'h5A};
        vt[4]  = '{1'b0,1'b1,1'b0,4'hF,11'h010,32'h00000000,1'b0,1'b0,11'h000,8'h00, 9'h004,32'h00000000,4'h0,1'b1,32'h5AFEBABE,8'h5A};
        vt[5]  = '{1'b1,1'b1,1'b1,4'h5,11'h020,32'h11223344,1'b0,1'b0,11'h000,8'h00, 9'h008,32'h11223344,4'h5,1'b1,32'h00000000,8'h5A};
        vt[6]  = '{1'b1,1'b1,1'b0,4'h0,11'h020,32'h00000000,1'b0,1'b0,11'h000,8'h00, 9'h008,32'h00000000,4'h0,1'b1,32'h00220044,8'h5A};
        vt[7]  = '{1'b0,1'b1,1'b0,4'hF,11'h010,32'hDEADBEEF,1'b1,1'b0,11'h012,8'h00, 9'h004,32'h00000000,4'h0,1'b0,32'h00000000,8'hFE};
        vt[8]  = '{1'b0,1'b1,1'b0,4'hF,11'h010,32'h00000000,1'b0,1'b0,11'h000,8'h00, 9'h004,32'h00000000,4'h0,1'b1,32'h5AFEBABE,8'hFE};
        vt[9]  = '{1'b0,1'b0,1'b0,4'h0,11'h000,32'h00000000,1'b1,1'b1,11'h021,8'h77, 9'h008,32'h77777777,4'h2,1'b0,32'h00000000,8'hFE};
        vt[10] = '{1'b0,1'b1,1'b0,4'hF,11'h020,32'h00000000,1'b0,1'b0,11'h000,8'h00, 9'h008,32'h00000000,4'h0,1'b1,32'h00227744,8'hFE};
        vt[11] = '{1'b1,1'b1,1'b0,4'hF,11'h020,32'h00000000,1'b1,1'b1,11'h013,8'h99, 9'h008,32'h00000000,4'h0,1'b1,32'h00227744,8'hFE};
        vt[12] = '{1'b0,1'b0,1'b0,4'h0,11'h000,32'h00000000,1'b1,1'b0,11'h013,8'h00, 9'h004,32'h00000000,4'h0,1'b0,32'h00000000,8'h5A};

        for (int k = 0; k < (1<<AW); k++) ref_mem[k] = 8'h00;

        // Reset with both sides requesting: nothing may reach the RAM or the acks.
        drive_idle();
        set_wb(1'b1, 4'hF, 11'h040, 32'h12345678);
        set_dp(1'b1, 11'h041, 8'hAA);
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst ram_wen", bus.ram_wen_o, 4'h0);
        chk("rst ram_a", bus.ram_a_o, 0);
        chk("rst ram_wd", bus.ram_wd_o, 32'h0);
        chk("rst acks", {bus.wb_ack_o, bus.dp_ack_o}, 2'b00);
        chk("rst dp_dat", bus.dp_dat_o, 8'h00);
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            exec_i = vt[i].exec;
            bus.wb_cyc_i = vt[i].wb_req; bus.wb_stb_i = vt[i].wb_req; bus.wb_we_i = vt[i].wb_we;
            bus.wb_sel_i = vt[i].sel;    bus.wb_adr_i = vt[i].wb_adr; bus.wb_dat_i = vt[i].wb_dat;
            bus.dp_req_i = vt[i].dp_req; bus.dp_we_i = vt[i].dp_we;   bus.dp_addr_i = vt[i].dp_adr;
            bus.dp_dat_i = vt[i].dp_dat;
            #1;
            chk($sformatf("v%0d grant ram_a", i), bus.ram_a_o, vt[i].e_a);
            chk($sformatf("v%0d grant ram_wd", i), bus.ram_wd_o, vt[i].e_wd);
            chk($sformatf("v%0d grant ram_wen", i), bus.ram_wen_o, vt[i].e_wen);
            chk($sformatf("v%0d grant acks", i), {bus.wb_ack_o, bus.dp_ack_o}, 2'b00);
            if (vt[i].e_wb && vt[i].wb_we) ref_wb_write(vt[i].sel, vt[i].wb_adr, vt[i].wb_dat);
            if (!vt[i].e_wb && vt[i].dp_we) ref_mem[vt[i].dp_adr] = vt[i].dp_dat;
            @(negedge clk_i);
            drive_idle();
            #1;
            chk($sformatf("v%0d ack pair", i), {bus.wb_ack_o, bus.dp_ack_o}, {vt[i].e_wb, ~vt[i].e_wb});
            chk($sformatf("v%0d ack ram_wen", i), bus.ram_wen_o, 4'h0);
            if (vt[i].e_wb) chk($sformatf("v%0d wb_dat", i), bus.wb_dat_o, vt[i].e_wbdat);
            else            chk($sformatf("v%0d dp_dat", i), bus.dp_dat_o, vt[i].e_dpdat);
        end

        // Held byte after the last read ack, and wb_dat_o zero outside an ack.
        @(negedge clk_i); #1;
        chk("dp_dat held", bus.dp_dat_o, 8'h5A);
        chk("wb_dat idle", bus.wb_dat_o, 32'h0);

        // Continuous contention with Wishbone priority.
        exp_order = '{2'b10,2'b10,2'b10,2'b10,2'b01,2'b10,2'b10,2'b10,2'b10,2'b01};
        exec_i = 1'b1;
        set_wb(1'b0, 4'hF, 11'h010, 32'h0);
        set_dp(1'b0, 11'h013, 8'h00);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.wb_ack_o && bus.dp_ack_o) chk("contend coincident acks", 2'b11, 2'b00);
            if (bus.wb_ack_o || bus.dp_ack_o) acks.push_back({bus.wb_ack_o, bus.dp_ack_o});
            @(negedge clk_i);
        end
        #1;
        if (bus.wb_ack_o || bus.dp_ack_o) acks.push_back({bus.wb_ack_o, bus.dp_ack_o});
        nack = acks.size();
        chk("contend ack count", nack, 10);
        for (int j = 0; j < 10 && j < nack; j++)
            chk($sformatf("contend order %0d", j), acks[j], exp_order[j]);
        drive_idle();
        @(negedge clk_i);

        // exec_i flips to Wishbone priority while a data-provider access is in flight.
        exec_i = 1'b0;
        set_wb(1'b0, 4'hF, 11'h020, 32'h0);
        set_dp(1'b0, 11'h013, 8'h00);
        #1;
        chk("exec flip dp grant", bus.ram_a_o, 9'h004);
        @(negedge clk_i);
        exec_i = 1'b1;
        #1;
        chk("exec flip dp ack", {bus.wb_ack_o, bus.dp_ack_o}, 2'b01);
        chk("exec flip dp byte", bus.dp_dat_o, 8'h5A);
        @(negedge clk_i); #1;
        chk("exec flip wb grant", bus.ram_a_o, 9'h008);
        @(negedge clk_i);
        drive_idle();
        #1;
        chk("exec flip wb ack", {bus.wb_ack_o, bus.dp_ack_o}, 2'b10);
        chk("exec flip wb dat", bus.wb_dat_o, 32'h00227744);

        // Reset during RESP_WB drops the ack at once; first edge after release grants the waiting DP write.
        @(negedge clk_i);
        set_wb(1'b0, 4'hF, 11'h010, 32'h0);
        @(posedge clk_i);
        #2;
        drive_idle();
        set_dp(1'b1, 11'h030, 8'h22);
        rst_i = 1'b1;
        #1;
        chk("midrst wb_ack", bus.wb_ack_o, 1'b0);
        chk("midrst wb_dat", bus.wb_dat_o, 32'h0);
        chk("midrst ram_wen", bus.ram_wen_o, 4'h0);
        chk("midrst dp_dat", bus.dp_dat_o, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("postrst grant ram_a", bus.ram_a_o, 9'h00C);
        chk("postrst grant ram_wen", bus.ram_wen_o, 4'h1);
        chk("postrst grant ram_wd", bus.ram_wd_o, 32'h22222222);
        ref_mem[11'h030] = 8'h22;
        @(negedge clk_i);
        drive_idle();
        #1;
        chk("postrst dp_ack", {bus.wb_ack_o, bus.dp_ack_o}, 2'b01);
        chk("postrst dp_dat held", bus.dp_dat_o, 8'h00);

        // Randomized traffic against the transaction-level model.
        m_cnt = 0;
        m_dpdat = 8'h00;
        for (int c = 0; c < 600; c++) begin
            logic          wbp, dpp, g_wb, g_dp;
            logic [AW-3:0] ea;
            logic [31:0]   ewd;
            logic [3:0]    ewen;
            exp_t          e;
            @(negedge clk_i);
            if ($urandom_range(0, 7) == 0) exec_i = ~exec_i;
            bus.wb_cyc_i  = ($urandom_range(0, 3) != 0);
            bus.wb_stb_i  = $urandom_range(0, 1) == 1;
            bus.wb_we_i   = $urandom_range(0, 1) == 1;
            bus.wb_sel_i  = 4'($urandom_range(0, 15));
            bus.wb_adr_i  = AW'($urandom_range(0, 63));
            bus.wb_dat_i  = $urandom;
            bus.dp_req_i  = $urandom_range(0, 1) == 1;
            bus.dp_we_i   = $urandom_range(0, 1) == 1;
            bus.dp_addr_i = AW'($urandom_range(0, 63));
            bus.dp_dat_i  = 8'($urandom_range(0, 255));
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rnd%0d resp acks", c), {bus.wb_ack_o, bus.dp_ack_o}, {e.is_wb, ~e.is_wb});
                chk($sformatf("rnd%0d resp ram", c), {bus.ram_wen_o, 23'(bus.ram_a_o) | 23'(|bus.ram_wd_o)}, 27'h0);
                if (e.is_wb) chk($sformatf("rnd%0d wb_dat", c), bus.wb_dat_o, e.wbdat);
                else begin
                    if (e.dp_rd) m_dpdat = e.dpdat;
                    chk($sformatf("rnd%0d dp_dat", c), bus.dp_dat_o, m_dpdat);
                end
            end else begin
                wbp = bus.wb_cyc_i & bus.wb_stb_i;
                dpp = bus.dp_req_i;
                g_wb = 1'b0; g_dp = 1'b0;
                if (wbp && dpp) begin
                    if (m_cnt == SL) begin
                        g_wb = ~exec_i; g_dp = exec_i; m_cnt = 0;
                    end else begin
                        g_wb = exec_i;  g_dp = ~exec_i; m_cnt = m_cnt + 1;
                    end
                end else if (wbp || dpp) begin
                    g_wb = wbp; g_dp = dpp; m_cnt = 0;
                end
                ea = '0; ewd = 32'h0; ewen = 4'h0;
                if (g_wb) begin
                    ea = bus.wb_adr_i[AW-1:2];
                    ewd = bus.wb_dat_i;
                    ewen = bus.wb_we_i ? bus.wb_sel_i : 4'h0;
                    e = '{1'b1, ref_word(bus.wb_adr_i), 1'b0, 8'h00};
                    exp_q.push_back(e);
                    ref_wb_write(ewen, bus.wb_adr_i, bus.wb_dat_i);
                end else if (g_dp) begin
                    ea = bus.dp_addr_i[AW-1:2];
                    ewd = {4{bus.dp_dat_i}};
                    ewen = bus.dp_we_i ? 4'(1 << bus.dp_addr_i[1:0]) : 4'h0;
                    e = '{1'b0, 32'h0, ~bus.dp_we_i, ref_mem[bus.dp_addr_i]};
                    exp_q.push_back(e);
                    if (bus.dp_we_i) ref_mem[bus.dp_addr_i] = bus.dp_dat_i;
                end
                chk($sformatf("rnd%0d grant ram", c), {bus.ram_wen_o, bus.ram_a_o, bus.ram_wd_o}, {ewen, ea, ewd});
                chk($sformatf("rnd%0d idle acks", c), {bus.wb_ack_o, bus.dp_ack_o, bus.wb_dat_o}, {2'b00, 32'h0});
                chk($sformatf("rnd%0d idle dp_dat", c), bus.dp_dat_o, m_dpdat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
